// File: rtl/tmr_pkg.sv
// Shared types and constants for the triple-modular-redundancy voter.
package tmr_pkg;

   typedef enum logic [1:0] {
      CH_GOOD    = 2'd0,
      CH_SUSPECT = 2'd1,
      CH_FAILED  = 2'd2
   } ch_state_t;

   localparam int CH_A = 0;
   localparam int CH_B = 1;
   localparam int CH_C = 2;

   // Bits needed to hold a consecutive-miss count from 0 up to limit.
   function automatic int consecWidth(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/tmr_channel_monitor.sv
// Per-channel health tracker: GOOD/SUSPECT/FAILED state, consecutive-miss
// counter and a saturating lifetime error counter.
module tmr_channel_monitor
   import tmr_pkg::*;
#(
   parameter int LIMIT = 3,
   parameter int CNTW  = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_sample,
   input  logic            i_disagree,
   input  logic            i_clrfail,
   output logic            o_failed,
   output logic [CNTW-1:0] o_errcnt
);

   localparam int CW = consecWidth(LIMIT);
   localparam logic [CW-1:0] LIM = CW'(LIMIT);
   localparam logic [CW-1:0] ONE = CW'(1);

   ch_state_t       r_state, w_stateNext;
   logic [CW-1:0]   r_count, w_countNext;
   logic [CNTW-1:0] r_errcnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= CH_GOOD;
         r_count <= '0;
      end else begin
         r_state <= w_stateNext;
         r_count <= w_countNext;
      end
   end

   // A clear always wins over a simultaneous sample.
   always_comb begin
      w_stateNext = r_state;
      w_countNext = r_count;
      if (i_clrfail) begin
         w_stateNext = CH_GOOD;
         w_countNext = '0;
      end else if (i_sample) begin
         case (r_state)
            CH_GOOD: begin
               if (i_disagree) begin
                  w_countNext = ONE;
                  w_stateNext = (LIM == ONE) ? CH_FAILED : CH_SUSPECT;
               end
            end
            CH_SUSPECT: begin
               if (!i_disagree) begin
                  w_stateNext = CH_GOOD;
                  w_countNext = '0;
               end else begin
                  w_countNext = r_count + ONE;
                  if ((r_count + ONE) == LIM) begin
                     w_stateNext = CH_FAILED;
                  end
               end
            end
            CH_FAILED: begin
            end
            default: begin
               w_stateNext = CH_GOOD;
               w_countNext = '0;
            end
         endcase
      end
   end

   // Lifetime count survives CLRFAIL; only reset clears it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_errcnt <= '0;
      end else if (i_sample && !i_clrfail && i_disagree && (r_errcnt != '1)) begin
         r_errcnt <= r_errcnt + {{(CNTW-1){1'b0}}, 1'b1};
      end
   end

   assign o_failed = (r_state == CH_FAILED);
   assign o_errcnt = r_errcnt;

endmodule

// File: rtl/tmr_voter.sv
// Majority voter for three replicated buses with per-channel exclusion,
// a breadboard-compatible bypass and registered V/VN outputs.
module tmr_voter
   import tmr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LIMIT = 3,
   parameter int CNTW  = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_sample,
   input  logic             i_bypass,
   input  logic             i_clrfail,
   input  logic [WIDTH-1:0] i_ina,
   input  logic [WIDTH-1:0] i_inb,
   input  logic [WIDTH-1:0] i_inc,
   output logic [WIDTH-1:0] o_vout,
   output logic [WIDTH-1:0] o_voutn,
   output logic             o_valid,
   output logic [2:0]       o_disagree,
   output logic [2:0]       o_failed,
   output logic             o_miscompare,
   output logic             o_dead,
   output logic [CNTW-1:0]  o_errcnta,
   output logic [CNTW-1:0]  o_errcntb,
   output logic [CNTW-1:0]  o_errcntc
);

   logic [WIDTH-1:0] w_in [3];
   logic [2:0]       w_failed;
   logic [2:0]       w_active;
   logic [2:0]       w_dis;
   logic             w_proc;
   logic [WIDTH-1:0] w_vote;
   logic             w_mis;
   logic             w_pairEn;
   logic [WIDTH-1:0] w_pairX, w_pairY;

   logic [WIDTH-1:0] r_vout, r_voutn;
   logic             r_valid, r_mis;
   logic [2:0]       r_dis;

   assign w_in[CH_A] = i_ina;
   assign w_in[CH_B] = i_inb;
   assign w_in[CH_C] = i_inc;
   assign w_active   = ~w_failed;
   assign w_proc     = i_sample & ~i_bypass & ~i_clrfail;

   // Active-set patterns below are indexed with A in bit 0, C in bit 2.
   always_comb begin
      w_vote   = r_vout;
      w_mis    = 1'b0;
      w_pairEn = 1'b0;
      w_pairX  = '0;
      w_pairY  = '0;
      case (w_active)
         3'b111:  w_vote = (i_ina & i_inb) | (i_ina & i_inc) | (i_inb & i_inc);
         3'b011:  begin w_pairEn = 1'b1; w_pairX = i_ina; w_pairY = i_inb; end
         3'b101:  begin w_pairEn = 1'b1; w_pairX = i_ina; w_pairY = i_inc; end
         3'b110:  begin w_pairEn = 1'b1; w_pairX = i_inb; w_pairY = i_inc; end
         3'b001:  w_vote = i_ina;
         3'b010:  w_vote = i_inb;
         3'b100:  w_vote = i_inc;
         default: w_vote = r_vout;
      endcase
      if (w_pairEn) begin
         if (w_pairX == w_pairY) begin
            w_vote = w_pairX;
         end else begin
            w_mis = 1'b1;
         end
      end
   end

   // An unresolvable pair blames both surviving channels.
   always_comb begin
      w_dis = '0;
      for (int i = 0; i < 3; i++) begin
         w_dis[i] = w_active[i] & (w_mis | (w_in[i] != w_vote));
      end
   end

   tmr_channel_monitor #(.LIMIT(LIMIT), .CNTW(CNTW)) u_monA (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sample(w_proc),
      .i_disagree(w_dis[CH_A]), .i_clrfail(i_clrfail),
      .o_failed(w_failed[CH_A]), .o_errcnt(o_errcnta)
   );

   tmr_channel_monitor #(.LIMIT(LIMIT), .CNTW(CNTW)) u_monB (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sample(w_proc),
      .i_disagree(w_dis[CH_B]), .i_clrfail(i_clrfail),
      .o_failed(w_failed[CH_B]), .o_errcnt(o_errcntb)
   );

   tmr_channel_monitor #(.LIMIT(LIMIT), .CNTW(CNTW)) u_monC (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sample(w_proc),
      .i_disagree(w_dis[CH_C]), .i_clrfail(i_clrfail),
      .o_failed(w_failed[CH_C]), .o_errcnt(o_errcntc)
   );

   // Bypass updates only the voted value; monitor-facing flags are held.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vout  <= '0;
         r_voutn <= '1;
         r_valid <= 1'b0;
         r_dis   <= '0;
         r_mis   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (i_clrfail) begin
            r_mis <= 1'b0;
         end else if (i_sample) begin
            r_valid <= 1'b1;
            if (i_bypass) begin
               r_vout  <= i_ina;
               r_voutn <= ~i_ina;
            end else begin
               r_vout  <= w_vote;
               r_voutn <= ~w_vote;
               r_dis   <= {w_dis[CH_A], w_dis[CH_B], w_dis[CH_C]};
               r_mis   <= w_mis;
            end
         end
      end
   end

   assign o_vout       = r_vout;
   assign o_voutn      = r_voutn;
   assign o_valid      = r_valid;
   assign o_disagree   = r_dis;
   assign o_miscompare = r_mis;
   assign o_failed     = {w_failed[CH_A], w_failed[CH_B], w_failed[CH_C]};
   assign o_dead       = &w_failed;

endmodule

// File: doc/tmr_voter.md
Name: tmr_voter

Overview:
- Parametrised triple-modular-redundancy voter. Replaces the straight single-channel bypass used on the breadboard computer with real majority voting of three replicated signal buses (e.g. G, OP, TR, PA/PB/PC groups).
- Tracks disagreement per channel and excludes a channel after repeated miscompares. Degrades gracefully down to one channel.
- Sits between the triplicated module outputs and the voted V/VN backplane nets.
- A BYPASS mode reproduces breadboard behaviour: channel A is passed through.

Parameters:
- WIDTH, 8: bits per channel bus.
- LIMIT, 3: consecutive disagreeing samples before a channel is marked FAILED. Range 1..15.
- CNTW, 8: width of the per-channel saturating total-error counters.

Ports:
- CLK  in  1  system clock.
- RSTN  in  1  asynchronous active-low reset.
- SAMPLE  in  1  vote strobe, one CLK wide, aligned to the consuming clock phase.
- BYPASS  in  1  1 = pass INA only, no monitoring.
- CLRFAIL  in  1  clears all channel states and consecutive counters.
- INA, INB, INC  in  WIDTH  replicated channel buses.
- VOUT  out  WIDTH  voted value (the V net).
- VOUTN  out  WIDTH  bitwise complement of VOUT (the VN net).
- VALID  out  1  one-cycle pulse when VOUT is updated.
- DISAGREE  out  3  per-channel [A,B,C] disagreement on the last processed sample.
- FAILED  out  3  per-channel excluded flags, sticky.
- MISCOMPARE  out  1  last sample was unresolvable; output held.
- DEAD  out  1  all three channels FAILED.
- ERRCNTA, ERRCNTB, ERRCNTC  out  CNTW  saturating total disagreement counts.

Behaviour:
- Reset (RSTN low, asynchronous): VOUT=0, VOUTN=all ones, VALID=0, DISAGREE=0, FAILED=0, MISCOMPARE=0, DEAD=0, all counters 0, all channels GOOD.
- All processing is on the CLK rising edge with SAMPLE=1. Outputs are registered with 1-cycle latency: a sample taken at edge n updates VOUT/VALID/flags at edge n. They are visible in the cycle after SAMPLE is asserted.
- VALID=1 only in the cycle after a processed sample. It is 0 otherwise.
- BYPASS=1: VOUT<=INA, VALID pulses. Channel states, counters, DISAGREE, MISCOMPARE and DEAD are all held. Toggling BYPASS mid-operation never alters monitor state.
- Voting (BYPASS=0), based on the active channels (not FAILED):
  - 3 active: bitwise majority of INA, INB, INC. Never MISCOMPARE.
  - 2 active: if the two buses are equal, VOUT<=that value. Otherwise VOUT holds and MISCOMPARE=1.
  - 1 active: VOUT<=that channel's value.
  - 0 active: VOUT holds, DEAD=1.
- A channel disagrees if it is active and its bus differs from the new voted VOUT in any bit.
- On a MISCOMPARE sample, both active channels count as disagreeing.
- FAILED channels never disagree.
- Per-channel state machine, updated only on processed samples:
  - GOOD: disagree -> SUSPECT, consecutive count=1. If LIMIT=1, go straight to FAILED.
  - SUSPECT: agree -> GOOD, count=0. Disagree -> count+1. When count reaches LIMIT -> FAILED.
  - FAILED: sticky until CLRFAIL or reset.
- ERRCNTx increments on every disagreement and saturates at 2^CNTW-1. It is not cleared by CLRFAIL; only reset clears it.
- CLRFAIL=1: all channels go GOOD, consecutive counts go to 0, FAILED=0, DEAD=0, MISCOMPARE=0.
- CLRFAIL has priority over SAMPLE in the same cycle. That sample is dropped: VOUT holds and VALID=0.
- VOUTN is always exactly ~VOUT. It is registered, not derived combinationally from the inputs.

Decomposition:
- Shared package tmr_pkg:
  - channel-state enum {CH_GOOD, CH_SUSPECT, CH_FAILED};
  - channel index constants CH_A=0, CH_B=1, CH_C=2;
  - a helper function for the consecutive-count width, $clog2(LIMIT+1).
- One sub-module, tmr_channel_monitor, instantiated three times. It holds the state machine, the consecutive counter and the saturating ERRCNT.
  - Inputs: SAMPLE qualifier, disagree, CLRFAIL.
  - Outputs: FAILED, ERRCNT.
- The top level holds the voter datapath and the output registers.

Test Plan (WIDTH=8, LIMIT=3, CNTW=8):
1. Reset, then SAMPLE with INA=8'h5A, INB=8'h5A, INC=8'hFF -> VOUT=8'h5A, VOUTN=8'hA5, VALID pulse, DISAGREE=3'b001 (C), ERRCNTC=1, FAILED=0.
2. Repeat the same stimulus for 3 samples total -> FAILED[C]=1 after the 3rd sample. A 4th sample with INC=8'h5A -> DISAGREE=0, FAILED[C] stays 1, ERRCNTC stays 3.
3. C disagrees twice, then agrees once, then disagrees twice -> FAILED[C]=0 throughout, ERRCNTC=4.
4. With C FAILED: INA=8'h11, INB=8'h22 -> VOUT holds 8'h5A, MISCOMPARE=1, DISAGREE=3'b110.
5. CLRFAIL and SAMPLE asserted in the same cycle -> VALID=0, FAILED=0, ERRCNT values unchanged. Then BYPASS=1 with INA=8'h3C, INB=INC=8'h00 -> VOUT=8'h3C and no counter changes.
6. ERRCNTA pre-driven to 255 by 255 disagreeing samples with CLRFAIL interleaved -> further disagreements keep ERRCNTA=255. Asserting RSTN=0 mid-stream -> all outputs return immediately to their reset values.
